spi_master_tx_shifter: RTL and testbench

Transmit serializer of the SPI master, directly downstream of the TX FIFO. It pops 32-bit words through a valid/ready handshake and presents them MSB-first on the SDO lines, one bit (standard) or one nibble (quad) per shift strobe. The strobe comes from the controller's clock generator. It stalls cleanly on FIFO underrun and reports end of segment to the controller FSM.

---
 rtl/spi_master_pkg.sv | 14 +
 rtl/spi_master_tx_shifter_if.sv | 21 ++
 rtl/spi_master_tx_shifter.sv | 157 +++++++++++++++
 tb/tb_spi_master_tx_shifter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// Shared types and widths for the SPI master transmit path.
package spi_master_pkg;

  localparam int unsigned SPI_WORD_W = 32;
  localparam int unsigned SPI_CNT_W  = 16;
  localparam int unsigned SPI_WCNT_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } tx_state_e;

endpackage

// File: rtl/spi_master_tx_shifter_if.sv
// Valid/ready word handshake between the TX FIFO and the transmit serializer.
interface spi_master_tx_shifter_if;
  import spi_master_pkg::*;

  logic [SPI_WORD_W-1:0] data_i;
  logic                  data_valid_i;
  logic                  data_ready_o;

  modport master (
    output data_i,
    output data_valid_i,
    input  data_ready_o
  );

  modport slave (
    input  data_i,
    input  data_valid_i,
    output data_ready_o
  );

endinterface

// File: rtl/spi_master_tx_shifter.sv
// SPI master TX serializer: pops 32-bit FIFO words and shifts them out MSB-first,
// one bit (standard) or one nibble (quad) per shift strobe.
module spi_master_tx_shifter
  import spi_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SPI_WORD_W,
  parameter int unsigned CNT_WIDTH  = SPI_CNT_W
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic                    quad_i,
  input  logic [CNT_WIDTH-1:0]    len_i,
  input  logic                    clk_en_i,
  spi_master_tx_shifter_if.slave  fifo_if,
  output logic [3:0]              sdo_o,
  output logic                    busy_o,
  output logic                    stall_o,
  output logic                    done_o
);

  // One extra bit so a rounded-up quad total never wraps.
  localparam int unsigned TOT_W  = CNT_WIDTH + 1;
  localparam int unsigned WCNT_W = SPI_WCNT_W;

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [TOT_W-1:0]      total_q, total_d;
  logic [WCNT_W-1:0]     word_cnt_q, word_cnt_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;
  logic                  quad_q, quad_d;
  logic                  stall_q, stall_d;
  logic                  done_q, done_d;

  logic [WCNT_W-1:0]     step;
  logic                  seg_last;
  logic                  word_end;
  logic                  data_ready_c;

  // Per-strobe end-of-segment and end-of-word decisions.
  always_comb begin
    step     = quad_q ? WCNT_W'(4) : WCNT_W'(1);
    seg_last = (total_q + TOT_W'(step)) >= TOT_W'(len_q);
    word_end = (word_cnt_q + step) == WCNT_W'(DATA_WIDTH);
  end

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    total_d      = total_q;
    word_cnt_d   = word_cnt_q;
    len_d        = len_q;
    quad_d       = quad_q;
    stall_d      = stall_q;
    done_d       = 1'b0;
    data_ready_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        stall_d = 1'b0;
        if (en_i) begin
          if (len_i != '0) begin
            len_d      = len_i;
            quad_d     = quad_i;
            total_d    = '0;
            word_cnt_d = '0;
            state_d    = LOAD;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      LOAD: begin
        data_ready_c = 1'b1;
        if (fifo_if.data_valid_i) begin
          sr_d       = fifo_if.data_i;
          word_cnt_d = '0;
          stall_d    = 1'b0;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        if (clk_en_i) begin
          total_d    = total_q + TOT_W'(step);
          word_cnt_d = word_cnt_q + step;
          sr_d       = quad_q ? (sr_q << 4) : (sr_q << 1);
          if (seg_last) begin
            // Leftover bits of the last word are discarded, never carried over.
            sr_d    = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (word_end) begin
            data_ready_c = 1'b1;
            if (fifo_if.data_valid_i) begin
              sr_d       = fifo_if.data_i;
              word_cnt_d = '0;
            end else begin
              stall_d = 1'b1;
              state_d = LOAD;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Soft reset aborts the segment silently and refuses any pop this cycle.
    if (clr_i) begin
      state_d      = IDLE;
      sr_d         = '0;
      total_d      = '0;
      word_cnt_d   = '0;
      stall_d      = 1'b0;
      done_d       = 1'b0;
      data_ready_c = 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      total_q    <= '0;
      word_cnt_q <= '0;
      len_q      <= '0;
      quad_q     <= 1'b0;
      stall_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      total_q    <= total_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      quad_q     <= quad_d;
      stall_q    <= stall_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    sdo_o = 4'b0000;
    if (state_q == SHIFT) begin
      sdo_o = quad_q ? sr_q[DATA_WIDTH-1 -: 4] : {3'b000, sr_q[DATA_WIDTH-1]};
    end
  end

  assign busy_o               = (state_q != IDLE);
  assign stall_o              = stall_q;
  assign done_o               = done_q;
  assign fifo_if.data_ready_o = data_ready_c;

endmodule

// File: tb/tb_spi_master_tx_shifter.sv
// Scoreboard bench for spi_master_tx_shifter: expected SDO symbols are queued per
// segment and popped on every shift strobe; a small FIFO model feeds the DUT.
module tb_spi_master_tx_shifter;
  import spi_master_pkg::*;

  logic        HCLK;
  logic        HRESETn;
  logic        clr_i;
  logic        en_i;
  logic        quad_i;
  logic [15:0] len_i;
  logic        clk_en_i;
  logic [3:0]  sdo_o;
  logic        busy_o;
  logic        stall_o;
  logic        done_o;

  spi_master_tx_shifter_if fifo_if ();

  spi_master_tx_shifter dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .clr_i    (clr_i),
    .en_i     (en_i),
    .quad_i   (quad_i),
    .len_i    (len_i),
    .clk_en_i (clk_en_i),
    .fifo_if  (fifo_if),
    .sdo_o    (sdo_o),
    .busy_o   (busy_o),
    .stall_o  (stall_o),
    .done_o   (done_o)
  );

  int n_checks;
  int n_fail;
  int pop_cnt;
  int exp_pops;
  int done_cnt;
  int seg_len;
  int seg_step;
  int k_sym;
  logic [31:0] fifo_q[$];
  logic [3:0]  exp_q[$];

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // TX FIFO model: pops on handshake, presents its head shortly after the edge.
  initial begin
    fifo_if.data_i       = 32'h0;
    fifo_if.data_valid_i = 1'b0;
    forever begin
      @(posedge HCLK);
      if (fifo_if.data_valid_i && fifo_if.data_ready_o) begin
        void'(fifo_q.pop_front());
        pop_cnt++;
      end
      #2;
      if (fifo_q.size() > 0) begin
        fifo_if.data_i       = fifo_q[0];
        fifo_if.data_valid_i = 1'b1;
      end else begin
        fifo_if.data_i       = 32'h0;
        fifo_if.data_valid_i = 1'b0;
      end
    end
  end

  always @(negedge HCLK) if (done_o === 1'b1) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic expect_seg(input int len, input bit quad, input logic [31:0] w0,
                            input logic [31:0] w1);
    int nsym;
    int bp;
    int off;
    logic [31:0] wd;
    seg_len  = len;
    seg_step = quad ? 4 : 1;
    k_sym    = 0;
    nsym     = (len + seg_step - 1) / seg_step;
    for (int k = 0; k < nsym; k++) begin
      bp  = k * seg_step;
      wd  = (bp < 32) ? w0 : w1;
      off = bp % 32;
      if (quad) exp_q.push_back(wd[31-off -: 4]);
      else      exp_q.push_back({3'b000, wd[31-off]});
    end
  endtask

  task automatic start(input int len, input bit quad);
    en_i   = 1'b1;
    len_i  = 16'(len);
    quad_i = quad;
    tick();
    en_i = 1'b0;
    chk("load_ready", 32'(fifo_if.data_ready_o), 32'd1);
    chk("load_busy", 32'(busy_o), 32'd1);
    chk("load_sdo", 32'(sdo_o), 32'd0);
    tick();
  endtask

  task automatic strobe(input int gap);
    int  tb;
    bit  last;
    k_sym++;
    tb       = k_sym * seg_step;
    last     = (tb >= seg_len);
    clk_en_i = 1'b1;
    @(negedge HCLK);
    if (exp_q.size() == 0) chk("sdo_sb_empty", 32'(exp_q.size()), 32'd1);
    else                   chk("sdo", 32'(sdo_o), 32'(exp_q.pop_front()));
    chk("ready_strobe", 32'(fifo_if.data_ready_o),
        (!last && (tb % 32 == 0)) ? 32'd1 : 32'd0);
    @(posedge HCLK);
    #1;
    clk_en_i = 1'b0;
    if (last) begin
      chk("done_end", 32'(done_o), 32'd1);
      chk("busy_end", 32'(busy_o), 32'd0);
    end else begin
      chk("done_early", 32'(done_o), 32'd0);
      chk("busy_mid", 32'(busy_o), 32'd1);
    end
    repeat (gap) tick();
  endtask

  task automatic seg_tail(input string tag);
    tick();
    chk("done_one_cycle", 32'(done_o), 32'd0);
    chk(tag, 32'(pop_cnt), 32'(exp_pops));
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; pop_cnt = 0; exp_pops = 0; done_cnt = 0;
    HRESETn = 1'b0; clr_i = 1'b0; en_i = 1'b0; quad_i = 1'b0;
    len_i = 16'd0; clk_en_i = 1'b0;
    repeat (3) tick();
    chk("rst_sdo", 32'(sdo_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_ready", 32'(fifo_if.data_ready_o), 32'd0);
    HRESETn = 1'b1;
    tick();

    // Standard, 8 bits, strobe every 4 cycles.
    fifo_q.push_back(32'hA500_0000); exp_pops += 1;
    expect_seg(8, 1'b0, 32'hA500_0000, 32'h0);
    start(8, 1'b0);
    for (int i = 1; i <= 8; i++) strobe((i < 8) ? 3 : 0);
    seg_tail("pops_std8");

    // Quad, 64 bits, back-to-back strobes across a word boundary.
    fifo_q.push_back(32'h1234_5678); fifo_q.push_back(32'h9ABC_DEF0); exp_pops += 2;
    expect_seg(64, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
    start(64, 1'b1);
    for (int i = 1; i <= 16; i++) strobe(0);
    seg_tail("pops_quad64");

    // Standard, 40 bits, second word arrives late.
    fifo_q.push_back(32'hC3A5_0F96); exp_pops += 2;
    expect_seg(40, 1'b0, 32'hC3A5_0F96, 32'h5A00_0000);
    start(40, 1'b0);
    for (int i = 1; i <= 32; i++) strobe(0);
    chk("stall_set", 32'(stall_o), 32'd1);
    chk("stall_sdo", 32'(sdo_o), 32'd0);
    for (int i = 0; i < 10; i++) begin
      clk_en_i = 1'b1;
      @(negedge HCLK);
      chk("stall_hold", 32'(stall_o), 32'd1);
      chk("stall_sdo_hold", 32'(sdo_o), 32'd0);
      @(posedge HCLK);
      #1;
    end
    clk_en_i = 1'b0;
    fifo_q.push_back(32'h5A00_0000);
    tick();
    chk("stall_clear", 32'(stall_o), 32'd0);
    for (int i = 33; i <= 40; i++) strobe((i < 40) ? 1 : 0);
    seg_tail("pops_std40");

    // Quad, 6 bits then 4 bits; each segment takes a fresh word.
    fifo_q.push_back(32'hCAFE_1234); exp_pops += 1;
    expect_seg(6, 1'b1, 32'hCAFE_1234, 32'h0);
    start(6, 1'b1);
    strobe(1);
    strobe(0);
    seg_tail("pops_quad6");
    fifo_q.push_back(32'h5BAD_F00D); exp_pops += 1;
    expect_seg(4, 1'b1, 32'h5BAD_F00D, 32'h0);
    start(4, 1'b1);
    strobe(0);
    seg_tail("pops_quad4");

    // Soft reset mid-segment, then a zero-length start.
    fifo_q.push_back(32'hE1E1_E1E1); exp_pops += 1;
    expect_seg(32, 1'b0, 32'hE1E1_E1E1, 32'h0);
    start(32, 1'b0);
    for (int i = 1; i <= 4; i++) strobe(1);
    clk_en_i = 1'b1;
    clr_i    = 1'b1;
    @(negedge HCLK);
    chk("sdo_clr_cycle", 32'(sdo_o), 32'(exp_q.pop_front()));
    @(posedge HCLK);
    #1;
    clr_i = 1'b0; clk_en_i = 1'b0;
    exp_q.delete();
    chk("clr_busy", 32'(busy_o), 32'd0);
    chk("clr_sdo", 32'(sdo_o), 32'd0);
    chk("clr_ready", 32'(fifo_if.data_ready_o), 32'd0);
    chk("clr_stall", 32'(stall_o), 32'd0);
    chk("clr_done", 32'(done_o), 32'd0);
    tick();
    chk("clr_no_done", 32'(done_o), 32'd0);
    chk("pops_clr", 32'(pop_cnt), 32'(exp_pops));

    fifo_q.push_back(32'h3C00_0000);
    en_i = 1'b1; len_i = 16'd0; quad_i = 1'b0;
    tick();
    en_i = 1'b0;
    chk("len0_done", 32'(done_o), 32'd1);
    chk("len0_busy", 32'(busy_o), 32'd0);
    chk("len0_ready", 32'(fifo_if.data_ready_o), 32'd0);
    tick();
    chk("len0_done_clear", 32'(done_o), 32'd0);
    chk("len0_no_pop", 32'(pop_cnt), 32'(exp_pops));
    chk("len0_fifo_kept", 32'(fifo_q.size()), 32'd1);

    // en_i during SHIFT must not alter the running segment.
    exp_pops += 1;
    expect_seg(8, 1'b0, 32'h3C00_0000, 32'h0);
    start(8, 1'b0);
    for (int i = 1; i <= 3; i++) strobe(1);
    en_i = 1'b1; len_i = 16'd4; quad_i = 1'b1;
    tick();
    en_i = 1'b0; quad_i = 1'b0;
    for (int i = 4; i <= 8; i++) strobe((i < 8) ? 1 : 0);
    seg_tail("pops_en_ignored");

    chk("done_count", 32'(done_cnt), 32'd7);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
